pc_sequencer: RTL and testbench

- Owns the fetch-stage program counter of the 5-stage pipelined MIPS core and decides the PC value for every cycle.
- Holds the PC through a post-reset boot window and on load-use stalls.
- Redirects the PC on taken branches and jumps, which are both resolved in ID, and flushes IF/ID on each redirect.
- Freezes the core once fetch would leave instruction memory.
- Sits between the hazard unit, ID-stage branch/jump logic, instruction memory and the IF/ID register.

---
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter sequencer for the 5-stage MIPS core
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 64,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Offset of the last fetchable word from the base; anything past it (or below
  // the base, which wraps to a huge offset) is outside instruction memory.
  localparam logic [31:0] SPAN      = 32'(4 * IMEM_WORDS - 4);
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;

  logic [31:0] next_pc;
  logic        redirect;
  logic        out_of_range;

  always_comb begin
    redirect = jump | branch_taken;
    if (jump) begin
      next_pc = jump_target & 32'hFFFF_FFFC;
    end else if (branch_taken) begin
      next_pc = branch_target & 32'hFFFF_FFFC;
    end else begin
      next_pc = pc_q + 32'd4;
    end
    out_of_range = (next_pc - RESET_PC) > SPAN;

    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    halted_d    = halted_q;
    if_id_write = 1'b0;
    if_id_flush = 1'b1;

    case (state_q)
      BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RUN: begin
        if (stall) begin
          if_id_flush = 1'b0;
        end else begin
          if_id_write = 1'b1;
          if_id_flush = redirect | out_of_range;
          if (out_of_range) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - bench for pc_sequencer: vector table, corner sequences, random vs model
module tb_pc_sequencer;

  localparam int BOOT_N = 2;
  localparam int WORDS  = 64;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] d_pc [2];
  logic [31:0] d_pp4 [2];
  logic        d_wr [2];
  logic        d_fl [2];
  logic        d_h [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .BOOT_CYCLES(BOOT_N)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(d_pc[0]), .pc_plus4(d_pp4[0]), .if_id_write(d_wr[0]), .if_id_flush(d_fl[0]),
    .halted(d_h[0]));

  pc_sequencer #(.RESET_PC(32'h10), .IMEM_WORDS(WORDS), .BOOT_CYCLES(BOOT_N)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(d_pc[1]), .pc_plus4(d_pp4[1]), .if_id_write(d_wr[1]), .if_id_flush(d_fl[1]),
    .halted(d_h[1]));

  // Reference model: pc value, boot cycles still to wait, frozen flag
  logic [31:0] m_pc [2];
  int          m_boot [2];
  bit          m_halt [2];

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0 : 32'h10;
  endfunction

  function automatic bit in_range(input int k, input logic [31:0] a);
    longint lo, hi;
    lo = longint'(base_of(k));
    hi = lo + 4 * WORDS - 4;
    return (longint'(a) >= lo) && (longint'(a) <= hi);
  endfunction

  function automatic logic [31:0] model_next(input int k);
    if (jump) return {jump_target[31:2], 2'b00};
    if (branch_taken) return {branch_target[31:2], 2'b00};
    return m_pc[k] + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
    reset = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    @(negedge clk);
  endtask

  task automatic check_model();
    bit idle, e_wr, e_fl;
    if (reset) return;
    for (int k = 0; k < 2; k++) begin
      idle = (m_boot[k] > 0) || m_halt[k];
      e_wr = !idle && !stall;
      e_fl = idle || (!stall && (jump || branch_taken || !in_range(k, model_next(k))));
      chk($sformatf("model_pc%0d", k), d_pc[k], m_pc[k]);
      chk($sformatf("model_pc_plus4_%0d", k), d_pp4[k], m_pc[k] + 32'd4);
      chk($sformatf("model_write%0d", k), 32'(d_wr[k]), 32'(e_wr));
      chk($sformatf("model_flush%0d", k), 32'(d_fl[k]), 32'(e_fl));
      chk($sformatf("model_halted%0d", k), 32'(d_h[k]), 32'(m_halt[k]));
    end
  endtask

  task automatic advance();
    logic [31:0] np;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = base_of(k); m_boot[k] = BOOT_N; m_halt[k] = 1'b0;
      end else if (m_halt[k]) begin
      end else if (m_boot[k] > 0) begin
        m_boot[k]--;
      end else if (!stall) begin
        np = model_next(k);
        if (in_range(k, np)) m_pc[k] = np;
        else m_halt[k] = 1'b1;
      end
    end
    #1;
  endtask

  typedef struct {
    bit r, s, b; logic [31:0] bt; bit j; logic [31:0] jt;
    logic [31:0] epc; bit ew, ef, eh;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit b, logic [31:0] bt, bit j, logic [31:0] jt,
                              logic [31:0] epc, bit ew, bit ef, bit eh);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.bt = bt; v.j = j; v.jt = jt;
    v.epc = epc; v.ew = ew; v.ef = ef; v.eh = eh;
    return v;
  endfunction

  initial begin
    //             r  s  b  bt     j  jt     pc     w  f  h
    tbl.push_back(mk(1, 0, 0, 0,     0, 0,     0,     0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'h8, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'hC, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h40, 0, 0,    32'h10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40, 0, 0,    32'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h20, 0, 0,    32'h40, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h44, 1, 32'h80, 32'h20, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h33, 0, 0,    32'h80, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h58, 0, 0,    32'h30, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h10, 0, 0,    32'h58, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'hF8, 0, 0,    0,     1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'hF8, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     32'hFC, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     1, 32'h10, 32'hFC, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 32'h8, 0, 0,     32'hFC, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,     0, 0,     32'hFC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h100, 0, 0,   0,     1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,     0, 0,     0,     0, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt);
      if (!tbl[i].r) begin
        chk($sformatf("vec%0d_pc", i), d_pc[0], tbl[i].epc);
        chk($sformatf("vec%0d_write", i), 32'(d_wr[0]), 32'(tbl[i].ew));
        chk($sformatf("vec%0d_flush", i), 32'(d_fl[0]), 32'(tbl[i].ef));
        chk($sformatf("vec%0d_halted", i), 32'(d_h[0]), 32'(tbl[i].eh));
        check_model();
      end
      advance();
    end

    // Base 0x10 instance: boot then branch far outside the range
    drive(1, 0, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0); chk("base10_boot_pc", d_pc[1], 32'h10); check_model(); advance();
    drive(0, 0, 0, 0, 0, 0); check_model(); advance();
    drive(0, 0, 1, 32'hFFFF_FFF0, 0, 0);
    chk("base10_run_pc", d_pc[1], 32'h10);
    chk("base10_oor_flush", 32'(d_fl[1]), 32'd1);
    check_model(); advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("base10_halted", 32'(d_h[1]), 32'd1);
    chk("base10_pc_frozen", d_pc[1], 32'h10);
    check_model(); advance();

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), 32'($urandom_range(0, 32'h140)),
            ($urandom_range(0, 7) == 0), 32'($urandom_range(0, 32'h140)));
      check_model();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
